// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: 1149.1 state machine, instruction register, BYPASS,
// IDCODE and a shared user shift register with per-user capture/update strobes.
module jtag_tap_ctrl #(
  parameter int unsigned          IR_WIDTH        = 4,
  parameter logic [31:0]          IDCODE_VAL      = 32'h1DC0_0A5F,
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR    = 4'h1,
  parameter int unsigned          USER_NR         = 2,
  parameter int unsigned          USER_DR_WIDTH   = 32,
  parameter logic [IR_WIDTH-1:0]  USER_INSTR_BASE = 4'h8
) (
  input  logic                               tck,
  input  logic                               trst,
  input  logic                               tms,
  input  logic                               tdi,
  output logic                               tdo,
  output logic                               tdo_oe,
  output logic [3:0]                         state,
  output logic [IR_WIDTH-1:0]                ir,
  output logic [USER_NR-1:0]                 user_sel,
  output logic [USER_NR-1:0]                 user_capture,
  input  logic [USER_NR*USER_DR_WIDTH-1:0]   user_capture_data,
  output logic [USER_NR-1:0]                 user_update,
  output logic [USER_DR_WIDTH-1:0]           user_update_data
);

  typedef enum logic [3:0] {
    TLR       = 4'hF,
    RTI       = 4'hC,
    SEL_DR    = 4'h7,
    CAP_DR    = 4'h6,
    SHIFT_DR  = 4'h2,
    EXIT1_DR  = 4'h1,
    PAUSE_DR  = 4'h3,
    EXIT2_DR  = 4'h0,
    UPD_DR    = 4'h5,
    SEL_IR    = 4'h4,
    CAP_IR    = 4'hE,
    SHIFT_IR  = 4'hA,
    EXIT1_IR  = 4'h9,
    PAUSE_IR  = 4'hB,
    EXIT2_IR  = 4'h8,
    UPD_IR    = 4'hD
  } tap_state_e;

  tap_state_e cur, nxt;

  logic [IR_WIDTH-1:0]      ir_shift;
  logic                     bypass_reg;
  logic [31:0]              idcode_shift;
  logic [USER_DR_WIDTH-1:0] user_shift;
  logic [USER_DR_WIDTH-1:0] cap_slice;
  logic                     is_idcode;
  logic                     user_hit;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) cur <= TLR;
    else      cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      TLR:      nxt = tms ? TLR      : RTI;
      RTI:      nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   nxt = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: nxt = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: nxt = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: nxt = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: nxt = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   nxt = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: nxt = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: nxt = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: nxt = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: nxt = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   nxt = tms ? SEL_DR   : RTI;
      default:  nxt = TLR;
    endcase
  end

  assign state = cur;

  // IDCODE wins over a colliding user opcode; all-ones is always BYPASS.
  always_comb begin
    user_sel  = '0;
    cap_slice = '0;
    is_idcode = (ir == IDCODE_INSTR);
    if (!is_idcode && ir != '1) begin
      for (int unsigned k = 0; k < USER_NR; k++) begin
        if (ir == IR_WIDTH'(USER_INSTR_BASE + k)) begin
          user_sel[k] = 1'b1;
          cap_slice   = user_capture_data[k*USER_DR_WIDTH +: USER_DR_WIDTH];
        end
      end
    end
    user_hit = |user_sel;
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir               <= IDCODE_INSTR;
      ir_shift         <= '0;
      bypass_reg       <= 1'b0;
      idcode_shift     <= '0;
      user_shift       <= '0;
      user_update_data <= '0;
      user_update      <= '0;
      user_capture     <= '0;
    end else begin
      user_update  <= '0;
      user_capture <= '0;
      case (cur)
        TLR:      ir       <= IDCODE_INSTR;
        CAP_IR:   ir_shift <= IR_WIDTH'(2'b01);
        SHIFT_IR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
        UPD_IR:   ir       <= ir_shift;
        CAP_DR: begin
          if (is_idcode) begin
            idcode_shift <= IDCODE_VAL;
          end else if (user_hit) begin
            user_shift   <= cap_slice;
            user_capture <= user_sel;
          end else begin
            bypass_reg <= 1'b0;
          end
        end
        SHIFT_DR: begin
          if (is_idcode)     idcode_shift <= {tdi, idcode_shift[31:1]};
          else if (user_hit) user_shift   <= {tdi, user_shift[USER_DR_WIDTH-1:1]};
          else               bypass_reg   <= tdi;
        end
        UPD_DR: begin
          if (user_hit) begin
            user_update_data <= user_shift;
            user_update      <= user_sel;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (cur == SHIFT_IR) begin
      tdo = ir_shift[0];
    end else if (cur == SHIFT_DR) begin
      if (is_idcode)     tdo = idcode_shift[0];
      else if (user_hit) tdo = user_shift[0];
      else               tdo = bypass_reg;
    end
  end

  assign tdo_oe = (cur == SHIFT_IR) || (cur == SHIFT_DR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: whole-scan reference model (capture value followed
// by shifted-in data) checked against TDO, IR and the user strobes.
module tb_jtag_tap_ctrl;
  localparam int IRW = 4;
  localparam int UN  = 2;
  localparam int UW  = 32;

  logic              tck = 1'b0;
  logic              trst, tms, tdi, tdo, tdo_oe;
  logic [3:0]        state;
  logic [IRW-1:0]    ir;
  logic [UN-1:0]     user_sel, user_capture, user_update;
  logic [UN*UW-1:0]  user_capture_data;
  logic [UW-1:0]     user_update_data;

  jtag_tap_ctrl #(
    .IR_WIDTH(IRW), .IDCODE_VAL(32'h1DC0_0A5F), .IDCODE_INSTR(4'h1),
    .USER_NR(UN), .USER_DR_WIDTH(UW), .USER_INSTR_BASE(4'h8)
  ) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .state(state), .ir(ir), .user_sel(user_sel), .user_capture(user_capture),
    .user_capture_data(user_capture_data), .user_update(user_update),
    .user_update_data(user_update_data)
  );

  always #5 tck = ~tck;

  int total = 0;
  int bad   = 0;
  logic [3:0]     nxt0 [16];
  logic [3:0]     nxt1 [16];
  logic [3:0]     mstate;
  logic [IRW-1:0] mir;
  logic [UW-1:0]  mupd;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Row per state: code, successor on tms=0, successor on tms=1.
  task automatic row(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic step(input logic t, input logic d);
    tms = t; tdi = d;
    @(posedge tck); #1;
    mstate = t ? nxt1[mstate] : nxt0[mstate];
    chk("state", state, mstate);
    chk("tdo_oe", tdo_oe, (mstate == 4'h2) || (mstate == 4'hA));
  endtask

  task automatic do_reset();
    tms = 1'b0; tdi = 1'b0; trst = 1'b1;
    repeat (2) @(posedge tck);
    #1;
    mstate = 4'hF; mir = 4'h1; mupd = '0;
    chk("rst_state", state, 4'hF);
    chk("rst_ir", ir, 4'h1);
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_tdo_oe", tdo_oe, 1'b0);
    chk("rst_upd", user_update, 2'b00);
    chk("rst_cap", user_capture, 2'b00);
    chk("rst_upd_data", user_update_data, 32'h0);
    @(negedge tck) trst = 1'b0;
  endtask

  // From RTI: full IR scan of v, back to RTI.
  task automatic ir_scan(input logic [IRW-1:0] v);
    logic [2*IRW-1:0] stream;
    stream = {v, IRW'(1)};
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IRW; i++) begin
      chk("ir_tdo", tdo, stream[i]);
      step(i == IRW - 1, v[i]);
    end
    step(1, 0);
    step(0, 0);
    mir = v;
    chk("ir", ir, mir);
    chk("ir_no_upd", user_update, 2'b00);
  endtask

  // From RTI: DR scan of n bits, optional Exit1/Pause/Exit2 detour after shift pause_at.
  task automatic dr_scan(input int n, input logic [63:0] data, input int pause_at);
    int len, uk;
    logic [127:0] cap, mask, seq, fin;
    logic [UN-1:0] oh;
    len = 1; uk = -1; oh = '0;
    if (mir == 4'h1) len = 32;
    else if (mir != 4'hF && mir >= 8 && mir < 8 + UN) begin uk = mir - 8; len = UW; oh[uk] = 1'b1; end
    mask = (128'(1) << len) - 128'(1);
    if (len == 32 && uk < 0) cap = 128'h1DC0_0A5F;
    else if (uk >= 0)        cap = (128'(user_capture_data) >> (uk * UW)) & mask;
    else                     cap = '0;
    seq = cap | (128'(data) << len);
    fin = (seq >> n) & mask;
    step(1, 0); step(0, 0); step(0, 0);
    chk("user_capture", user_capture, oh);
    for (int i = 0; i < n; i++) begin
      chk("dr_tdo", tdo, seq[i]);
      step((i == n - 1) || (i == pause_at), data[i]);
      if (i == 0) chk("capture_1cyc", user_capture, 2'b00);
      if (i != n - 1 && i == pause_at) begin
        step(0, 0); step(0, 1); step(1, 0); step(0, 0);
      end
    end
    step(1, 0);
    chk("upd_early", user_update, 2'b00);
    step(0, 0);
    if (uk >= 0) mupd = fin[UW-1:0];
    chk("user_update", user_update, oh);
    chk("user_update_data", user_update_data, mupd);
    step(0, 0);
    chk("update_1cyc", user_update, 2'b00);
  endtask

  initial begin
    logic [IRW-1:0] pick [6];
    int n;
    row(4'hF, 4'hC, 4'hF); row(4'hC, 4'hC, 4'h7); row(4'h7, 4'h6, 4'h4);
    row(4'h6, 4'h2, 4'h1); row(4'h2, 4'h2, 4'h1); row(4'h1, 4'h3, 4'h5);
    row(4'h3, 4'h3, 4'h0); row(4'h0, 4'h2, 4'h5); row(4'h5, 4'hC, 4'h7);
    row(4'h4, 4'hE, 4'hF); row(4'hE, 4'hA, 4'h9); row(4'hA, 4'hA, 4'h9);
    row(4'h9, 4'hB, 4'hD); row(4'hB, 4'hB, 4'h8); row(4'h8, 4'hA, 4'hD);
    row(4'hD, 4'hC, 4'h7);
    pick[0] = 4'h1; pick[1] = 4'h8; pick[2] = 4'h9;
    pick[3] = 4'h3; pick[4] = 4'hF; pick[5] = 4'h0;
    user_capture_data = {$urandom, $urandom};

    // IDCODE after reset
    do_reset();
    step(0, 0);
    dr_scan(32, {$urandom, $urandom}, -1);

    // BYPASS via all-ones
    ir_scan(4'hF);
    dr_scan(4, 64'b1101, -1);

    // user DR 1
    user_capture_data = {32'hCAFE_F00D, $urandom};
    ir_scan(4'h9);
    dr_scan(32, 64'h1234_5678, -1);
    chk("user1_data", user_update_data, 32'h1234_5678);

    // undefined opcode behaves as bypass, with a pause detour
    ir_scan(4'h3);
    dr_scan(6, {$urandom, $urandom}, 2);

    for (int it = 0; it < 14; it++) begin
      user_capture_data = {$urandom, $urandom};
      pick[5] = 4'($urandom);
      ir_scan(pick[$urandom_range(0, 5)]);
      n = $urandom_range(1, 40);
      dr_scan(n, {$urandom, $urandom}, $urandom_range(0, n + 3));
    end

    // five tms=1 from Shift-IR reach TLR; one more TLR edge restores IDCODE
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1'($urandom));
      chk("tlr_no_upd", user_update, 2'b00);
    end
    chk("tlr_state", state, 4'hF);
    step(1, 0);
    mir = 4'h1;
    chk("tlr_ir", ir, mir);

    // asynchronous reset in the middle of a user DR shift
    do_reset();
    step(0, 0);
    user_capture_data = {$urandom, $urandom};
    ir_scan(4'h8);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) step(0, 1);
    #2 trst = 1'b1;
    #1;
    chk("arst_state", state, 4'hF);
    chk("arst_ir", ir, 4'h1);
    chk("arst_tdo_oe", tdo_oe, 1'b0);
    chk("arst_tdo", tdo, 1'b0);
    chk("arst_upd", user_update, 2'b00);
    chk("arst_upd_data", user_update_data, mupd);
    @(negedge tck) trst = 1'b0;
    mstate = 4'hF; mir = 4'h1;
    step(0, 0);
    step(0, 0);
    chk("post_arst_upd", user_update, 2'b00);
    chk("post_arst_ir", ir, mir);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
